// File: rtl/coco_kbd_pkg.sv
// rtl/coco_kbd_pkg.sv - shared types and constants for the PS/2 to CoCo keyboard matrix
package coco_kbd_pkg;

    localparam int TOGGLE_BIT = 10;
    localparam int NUM_ROWS   = 7;
    localparam int NUM_COLS   = 8;

    // Position of the CoCo SHIFT key in the matrix
    localparam int ROW_SHIFT  = 6;
    localparam int COL_SHIFT  = 7;

    // Host shift scancodes (set 2, non-extended)
    localparam logic [7:0] SC_LSHIFT = 8'h12;
    localparam logic [7:0] SC_RSHIFT = 8'h59;

    typedef enum logic [1:0] {
        SMODE_NONE = 2'd0,
        SMODE_ON   = 2'd1,
        SMODE_OFF  = 2'd2
    } smode_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DECODE = 2'd1,
        ST_UPDATE = 2'd2
    } state_e;

    typedef struct packed {
        logic       valid;
        logic [2:0] row;
        logic [2:0] col;
        smode_e     smode;
    } lut_res_t;

    function automatic lut_res_t key_at(input int row, input int col, input smode_e sm);
        lut_res_t r;
        r.valid = 1'b1;
        r.row   = row[2:0];
        r.col   = col[2:0];
        r.smode = sm;
        return r;
    endfunction

endpackage

// File: rtl/ps2_coco_matrix_if.sv
// rtl/ps2_coco_matrix_if.sv - keyboard event / PIA0 row-column bundle
// Signals: ps2_key[10:0] event word, kb_cols[7:0] column strobes (active-low),
// joy_btn_r/joy_btn_l fire buttons, kb_rows[6:0] row levels (active-low), key_event pulse.
// master = host/PIA side driving events and strobes; slave = the matrix block.
interface ps2_coco_matrix_if;
    logic [10:0] ps2_key;
    logic [7:0]  kb_cols;
    logic        joy_btn_r;
    logic        joy_btn_l;
    logic [6:0]  kb_rows;
    logic        key_event;

    modport master (
        output ps2_key, kb_cols, joy_btn_r, joy_btn_l,
        input  kb_rows, key_event
    );

    modport slave (
        input  ps2_key, kb_cols, joy_btn_r, joy_btn_l,
        output kb_rows, key_event
    );
endinterface

// File: rtl/coco_key_lut.sv
// rtl/coco_key_lut.sv - combinational set-2 scancode to CoCo matrix position table
// Inputs: ext (extended prefix), code[7:0] scancode, pc_shift_any (host shift held).
// Output: res = {valid, row, col, smode}; smode forces the CoCo SHIFT level while the key is held.
module coco_key_lut
    import coco_kbd_pkg::*;
(
    input  logic       ext,
    input  logic [7:0] code,
    input  logic       pc_shift_any,
    output lut_res_t   res
);

    always_comb begin
        res = '0;
        if (!ext) begin
            case (code)
                // row 0: @ A-G ('@' only via host Shift+2, see 8'h1E)
                8'h1C: res = key_at(0, 1, SMODE_NONE);
                8'h32: res = key_at(0, 2, SMODE_NONE);
                8'h21: res = key_at(0, 3, SMODE_NONE);
                8'h23: res = key_at(0, 4, SMODE_NONE);
                8'h24: res = key_at(0, 5, SMODE_NONE);
                8'h2B: res = key_at(0, 6, SMODE_NONE);
                8'h34: res = key_at(0, 7, SMODE_NONE);
                // row 1: H-O
                8'h33: res = key_at(1, 0, SMODE_NONE);
                8'h43: res = key_at(1, 1, SMODE_NONE);
                8'h3B: res = key_at(1, 2, SMODE_NONE);
                8'h42: res = key_at(1, 3, SMODE_NONE);
                8'h4B: res = key_at(1, 4, SMODE_NONE);
                8'h3A: res = key_at(1, 5, SMODE_NONE);
                8'h31: res = key_at(1, 6, SMODE_NONE);
                8'h44: res = key_at(1, 7, SMODE_NONE);
                // row 2: P-W
                8'h4D: res = key_at(2, 0, SMODE_NONE);
                8'h15: res = key_at(2, 1, SMODE_NONE);
                8'h2D: res = key_at(2, 2, SMODE_NONE);
                8'h1B: res = key_at(2, 3, SMODE_NONE);
                8'h2C: res = key_at(2, 4, SMODE_NONE);
                8'h3C: res = key_at(2, 5, SMODE_NONE);
                8'h2A: res = key_at(2, 6, SMODE_NONE);
                8'h1D: res = key_at(2, 7, SMODE_NONE);
                // row 3: X Y Z, backspace acts as LEFT, space
                8'h22: res = key_at(3, 0, SMODE_NONE);
                8'h35: res = key_at(3, 1, SMODE_NONE);
                8'h1A: res = key_at(3, 2, SMODE_NONE);
                8'h66: res = key_at(3, 5, SMODE_NONE);
                8'h29: res = key_at(3, 7, SMODE_NONE);
                // row 4: 0-7; Shift+2 is '@' on the host but unshifted on the CoCo
                8'h45: res = key_at(4, 0, SMODE_NONE);
                8'h16: res = key_at(4, 1, SMODE_NONE);
                8'h1E: res = pc_shift_any ? key_at(0, 0, SMODE_OFF) : key_at(4, 2, SMODE_NONE);
                8'h26: res = key_at(4, 3, SMODE_NONE);
                8'h25: res = key_at(4, 4, SMODE_NONE);
                8'h2E: res = key_at(4, 5, SMODE_NONE);
                8'h36: res = key_at(4, 6, SMODE_NONE);
                8'h3D: res = key_at(4, 7, SMODE_NONE);
                // apostrophe is CoCo Shift+7
                8'h52: res = key_at(4, 7, SMODE_ON);
                // row 5: 8 9 : ; , - . /
                8'h3E: res = key_at(5, 0, SMODE_NONE);
                8'h46: res = key_at(5, 1, SMODE_NONE);
                8'h4C: res = pc_shift_any ? key_at(5, 2, SMODE_OFF) : key_at(5, 3, SMODE_NONE);
                8'h41: res = key_at(5, 4, SMODE_NONE);
                8'h4E: res = key_at(5, 5, SMODE_NONE);
                8'h49: res = key_at(5, 6, SMODE_NONE);
                8'h4A: res = key_at(5, 7, SMODE_NONE);
                // '=' is CoCo Shift+'-'
                8'h55: res = key_at(5, 5, SMODE_ON);
                // row 6: ENTER, ESC acts as BREAK
                8'h5A: res = key_at(6, 0, SMODE_NONE);
                8'h76: res = key_at(6, 2, SMODE_NONE);
                default: res = '0;
            endcase
        end else begin
            case (code)
                8'h75: res = key_at(3, 3, SMODE_NONE);
                8'h72: res = key_at(3, 4, SMODE_NONE);
                8'h6B: res = key_at(3, 5, SMODE_NONE);
                8'h74: res = key_at(3, 6, SMODE_NONE);
                8'h6C: res = key_at(6, 1, SMODE_NONE);
                8'h5A: res = key_at(6, 0, SMODE_NONE);
                default: res = '0;
            endcase
        end
    end

endmodule

// File: rtl/ps2_coco_matrix.sv
// rtl/ps2_coco_matrix.sv - hps_io ps2_key events to CoCo 2 7x8 keyboard matrix with PIA0 readback
// Ports: clk, reset (async, active-low), bus (slave): ps2_key in, kb_cols in (active-low strobes),
// joy_btn_r/joy_btn_l in, kb_rows out (registered, active-low), key_event out (1-cycle pulse).
module ps2_coco_matrix
    import coco_kbd_pkg::*;
#(
    parameter int TOGGLE_BIT = 10,
    parameter int NUM_ROWS   = 7,
    parameter int NUM_COLS   = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    ps2_coco_matrix_if.slave     bus
);

    state_e state, state_nxt;

    logic       toggle_q;
    logic       new_ev;
    logic       ev_pressed, ev_ext;
    logic [7:0] ev_code;
    logic       pend_valid, pend_pressed, pend_ext;
    logic [7:0] pend_code;

    lut_res_t lut_out, lut_q;

    logic [NUM_ROWS-1:0][NUM_COLS-1:0] matrix, matrix_nxt;
    logic [1:0] pc_shift, pc_shift_nxt;
    smode_e     ovr_mode, ovr_mode_nxt;
    logic [8:0] ovr_code, ovr_code_nxt;
    logic [2:0] ovr_row, ovr_row_nxt, ovr_col, ovr_col_nxt;
    logic       changed;
    logic       shift_eff;
    logic       key_event_q;
    logic [NUM_ROWS-1:0] rows_nxt, rows_q;

    assign new_ev = bus.ps2_key[TOGGLE_BIT] != toggle_q;

    coco_key_lut u_lut (
        .ext          (ev_ext),
        .code         (ev_code),
        .pc_shift_any (|pc_shift),
        .res          (lut_out)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:   if (new_ev || pend_valid) state_nxt = ST_DECODE;
            ST_DECODE: state_nxt = ST_UPDATE;
            ST_UPDATE: state_nxt = ST_IDLE;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    // Event capture: an older pending event is always served before a fresh one.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            toggle_q     <= bus.ps2_key[TOGGLE_BIT];
            ev_pressed   <= 1'b0;
            ev_ext       <= 1'b0;
            ev_code      <= '0;
            pend_valid   <= 1'b0;
            pend_pressed <= 1'b0;
            pend_ext     <= 1'b0;
            pend_code    <= '0;
            lut_q        <= '0;
        end else begin
            toggle_q <= bus.ps2_key[TOGGLE_BIT];
            if (state == ST_IDLE) begin
                if (pend_valid) begin
                    ev_pressed <= pend_pressed;
                    ev_ext     <= pend_ext;
                    ev_code    <= pend_code;
                    pend_valid <= new_ev;
                    if (new_ev) begin
                        pend_pressed <= bus.ps2_key[9];
                        pend_ext     <= bus.ps2_key[8];
                        pend_code    <= bus.ps2_key[7:0];
                    end
                end else if (new_ev) begin
                    ev_pressed <= bus.ps2_key[9];
                    ev_ext     <= bus.ps2_key[8];
                    ev_code    <= bus.ps2_key[7:0];
                end
            end else if (new_ev) begin
                pend_valid   <= 1'b1;
                pend_pressed <= bus.ps2_key[9];
                pend_ext     <= bus.ps2_key[8];
                pend_code    <= bus.ps2_key[7:0];
            end
            if (state == ST_DECODE) lut_q <= lut_out;
        end
    end

    always_comb begin
        matrix_nxt   = matrix;
        pc_shift_nxt = pc_shift;
        ovr_mode_nxt = ovr_mode;
        ovr_code_nxt = ovr_code;
        ovr_row_nxt  = ovr_row;
        ovr_col_nxt  = ovr_col;
        if (!ev_ext && (ev_code == SC_LSHIFT || ev_code == SC_RSHIFT)) begin
            if (ev_code == SC_LSHIFT) pc_shift_nxt[0] = ev_pressed;
            else                      pc_shift_nxt[1] = ev_pressed;
        end else if (lut_q.valid) begin
            matrix_nxt[lut_q.row][lut_q.col] = ev_pressed;
            if (ev_pressed && lut_q.smode != SMODE_NONE) begin
                ovr_mode_nxt = lut_q.smode;
                ovr_code_nxt = {ev_ext, ev_code};
                ovr_row_nxt  = lut_q.row;
                ovr_col_nxt  = lut_q.col;
            end else if (!ev_pressed && ovr_mode != SMODE_NONE && {ev_ext, ev_code} == ovr_code) begin
                // The override key may have been pressed under a different host shift
                // state, so release the cell it actually set, not just the one looked up now.
                ovr_mode_nxt = SMODE_NONE;
                matrix_nxt[ovr_row][ovr_col] = 1'b0;
            end
        end
        changed = (matrix_nxt != matrix) || (pc_shift_nxt != pc_shift) || (ovr_mode_nxt != ovr_mode);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            matrix      <= '0;
            pc_shift    <= '0;
            ovr_mode    <= SMODE_NONE;
            ovr_code    <= '0;
            ovr_row     <= '0;
            ovr_col     <= '0;
            key_event_q <= 1'b0;
        end else if (state == ST_UPDATE) begin
            matrix      <= matrix_nxt;
            pc_shift    <= pc_shift_nxt;
            ovr_mode    <= ovr_mode_nxt;
            ovr_code    <= ovr_code_nxt;
            ovr_row     <= ovr_row_nxt;
            ovr_col     <= ovr_col_nxt;
            key_event_q <= changed;
        end else begin
            key_event_q <= 1'b0;
        end
    end

    assign shift_eff = (ovr_mode == SMODE_ON)  ? 1'b1 :
                       (ovr_mode == SMODE_OFF) ? 1'b0 : |pc_shift;

    always_comb begin
        rows_nxt = '1;
        for (int r = 0; r < NUM_ROWS; r++) begin
            for (int c = 0; c < NUM_COLS; c++) begin
                if (!bus.kb_cols[c] &&
                    ((r == ROW_SHIFT && c == COL_SHIFT) ? shift_eff : matrix[r][c]))
                    rows_nxt[r] = 1'b0;
            end
        end
        if (bus.joy_btn_r) rows_nxt[0] = 1'b0;
        if (bus.joy_btn_l) rows_nxt[1] = 1'b0;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) rows_q <= '1;
        else        rows_q <= rows_nxt;
    end

    assign bus.kb_rows   = rows_q;
    assign bus.key_event = key_event_q;

endmodule

// File: tb/tb_ps2_coco_matrix.sv
// tb/tb_ps2_coco_matrix.sv - directed self-checking bench for ps2_coco_matrix
module tb_ps2_coco_matrix;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic tgl = 1'b0;
    int   errors = 0;
    int   checks = 0;
    int   pulses;

    ps2_coco_matrix_if bus ();

    ps2_coco_matrix dut (
        .clk   (clk),
        .reset (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        repeat (n) tick();
    endtask

    task automatic send(input logic pressed, input logic ext, input logic [7:0] code);
        tgl = ~tgl;
        bus.ps2_key = {tgl, pressed, ext, code};
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        bus.ps2_key   = '0;
        bus.kb_cols   = 8'h00;
        bus.joy_btn_r = 1'b0;
        bus.joy_btn_l = 1'b0;

        // Reset state
        ticks(2);
        chk("reset_rows", bus.kb_rows, 7'h7F);
        chk("reset_event", bus.key_event, 1'b0);
        rst_n = 1'b1;
        tick();
        chk("idle_rows", bus.kb_rows, 7'h7F);

        // Joystick fire buttons
        bus.joy_btn_r = 1'b1;
        tick();
        chk("joy_r", bus.kb_rows, 7'h7E);
        bus.joy_btn_r = 1'b0;
        bus.joy_btn_l = 1'b1;
        tick();
        chk("joy_l", bus.kb_rows, 7'h7D);
        bus.joy_btn_l = 1'b0;
        tick();

        // 'A' press: key_event at 3 cycles, rows at 4
        bus.kb_cols = 8'hFD;
        send(1'b1, 1'b0, 8'h1C);
        ticks(2);
        chk("a_event_early", bus.key_event, 1'b0);
        tick();
        chk("a_event", bus.key_event, 1'b1);
        chk("a_rows_early", bus.kb_rows, 7'h7F);
        tick();
        chk("a_rows", bus.kb_rows, 7'h7E);
        chk("a_event_end", bus.key_event, 1'b0);
        send(1'b0, 1'b0, 8'h1C);
        ticks(4);
        chk("a_release", bus.kb_rows, 7'h7F);

        // Host Shift+2 gives unshifted CoCo '@'
        bus.kb_cols = 8'h7F;
        send(1'b1, 1'b0, 8'h12);
        ticks(4);
        chk("shift_only", bus.kb_rows, 7'h3F);
        send(1'b1, 1'b0, 8'h1E);
        ticks(4);
        chk("at_shift_forced_off", bus.kb_rows, 7'h7F);
        bus.kb_cols = 8'hFE;
        tick();
        chk("at_key", bus.kb_rows, 7'h7E);
        bus.kb_cols = 8'h7F;
        send(1'b0, 1'b0, 8'h1E);
        ticks(4);
        chk("at_release_shift_back", bus.kb_rows, 7'h3F);
        bus.kb_cols = 8'hFE;
        tick();
        chk("at_released", bus.kb_rows, 7'h7F);
        bus.kb_cols = 8'h7F;
        send(1'b0, 1'b0, 8'h12);
        ticks(4);
        chk("shift_released", bus.kb_rows, 7'h7F);

        // Apostrophe forces SHIFT on together with '7'
        send(1'b1, 1'b0, 8'h52);
        ticks(4);
        chk("apos_shift7", bus.kb_rows, 7'h2F);
        send(1'b0, 1'b0, 8'h52);
        ticks(4);
        chk("apos_release", bus.kb_rows, 7'h7F);

        // Extended UP vs unmapped non-extended 0x75
        bus.kb_cols = 8'hF7;
        send(1'b1, 1'b1, 8'h75);
        ticks(3);
        chk("up_event", bus.key_event, 1'b1);
        tick();
        chk("up_rows", bus.kb_rows, 7'h77);
        send(1'b1, 1'b0, 8'h75);
        pulses = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (bus.key_event) pulses++;
        end
        chk("kp8_no_event", pulses, 0);
        chk("kp8_rows", bus.kb_rows, 7'h77);
        send(1'b0, 1'b1, 8'h75);
        ticks(4);
        chk("up_release", bus.kb_rows, 7'h7F);

        // Extended Enter lands on row6 col0
        bus.kb_cols = 8'hFE;
        send(1'b1, 1'b1, 8'h5A);
        ticks(4);
        chk("kp_enter", bus.kb_rows, 7'h3F);
        send(1'b0, 1'b1, 8'h5A);
        ticks(4);
        chk("kp_enter_release", bus.kb_rows, 7'h7F);

        // Back-to-back events: the second is held pending and still processed
        bus.kb_cols = 8'hF9;
        pulses = 0;
        send(1'b1, 1'b0, 8'h1C);
        tick();
        if (bus.key_event) pulses++;
        send(1'b1, 1'b0, 8'h32);
        for (int i = 0; i < 9; i++) begin
            tick();
            if (bus.key_event) pulses++;
        end
        chk("pair_pulses", pulses, 2);
        chk("pair_rows", bus.kb_rows, 7'h7E);
        bus.kb_cols = 8'hFB;
        tick();
        chk("pair_b_held", bus.kb_rows, 7'h7E);
        send(1'b0, 1'b0, 8'h32);
        ticks(4);
        chk("pair_b_released", bus.kb_rows, 7'h7F);
        bus.kb_cols = 8'hFD;
        tick();
        chk("pair_a_held", bus.kb_rows, 7'h7E);

        // Reset while a second event sits in DECODE
        send(1'b1, 1'b0, 8'h32);
        tick();
        rst_n = 1'b0;
        #1;
        chk("midreset_rows", bus.kb_rows, 7'h7F);
        chk("midreset_event", bus.key_event, 1'b0);
        tick();
        rst_n = 1'b1;
        bus.kb_cols = 8'h00;
        pulses = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (bus.key_event) pulses++;
        end
        chk("postreset_no_event", pulses, 0);
        chk("postreset_empty", bus.kb_rows, 7'h7F);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ps2_coco_matrix.md
Name: ps2_coco_matrix

Overview:
- Converts the hps_io `ps2_key` event word into the CoCo 2 7x8 keyboard matrix state, and answers PIA0 column-strobe reads with row levels.
- Sits directly upstream of the po8 PIA0 keyboard path: PB column strobes in, PA0–PA6 row levels out.
- Also merges the two joystick fire buttons onto PA0/PA1.
- Handles host-vs-CoCo shift mismatches, e.g. PC Shift+2 produces CoCo '@', which is an unshifted key on the CoCo.

Parameters:
- TOGGLE_BIT, 10, bit index of the event toggle in ps2_key
- NUM_ROWS, 7, matrix rows (PA0–PA6)
- NUM_COLS, 8, matrix columns (PB0–PB7)

Ports:
- clk  input  1  system clock (clk_sys domain)
- reset  input  1  asynchronous, active-low; clears all matrix state
- ps2_key  input  11  [10] toggle, [9] pressed, [8] extended, [7:0] set-2 scancode
- kb_cols  input  8  PIA0 PB column strobes; active-low, multiple columns may be low at once
- joy_btn_r  input  1  right joystick fire, active-high
- joy_btn_l  input  1  left joystick fire, active-high
- kb_rows  output  7  PA0–PA6 row levels; active-low; registered
- key_event  output  1  one-cycle pulse when the matrix changes (debug/LED)

Behaviour:
- Reset (reset=0):
  - matrix, pc_shift, ovr_mode, ovr_code all cleared.
  - Toggle-history register loads ps2_key[10], so a stale event is not replayed.
  - kb_rows=7'h7F, key_event=0, FSM in IDLE.
- Event detect: toggle_q <= ps2_key[10] each cycle. A new event is ps2_key[10] != toggle_q. Capture {pressed, ext, code} into ev_* on that cycle.
- FSM states:
  - IDLE: on new event -> DECODE.
  - DECODE: one cycle. Lookup sub-module returns {valid, row[2:0], col[2:0], smode[1:0]}; smode: 0=none, 1=force shift on, 2=force shift off. -> UPDATE.
  - UPDATE: one cycle. Apply the event, pulse key_event if any state changed. -> IDLE.
  - Latency: event to key_event = 3 cycles; event to kb_rows change = 4 cycles.
- Events arriving while in DECODE/UPDATE: latch the toggle change and process it on return to IDLE. Hold at most one pending event; a newer one overwrites it. hps_io event spacing makes overwrite unreachable in practice.
- Host shift: code 0x12 or 0x59 (non-ext) sets/clears pc_shift[0]/[1] respectively. Shift events do not touch the matrix directly.
- Mapped key (valid=1):
  - Press sets matrix[row][col]; release clears it.
  - If smode!=0 on press: ovr_mode <= smode, ovr_code <= {ext, code}.
  - Release of a key whose {ext, code} == ovr_code clears ovr_mode.
- Unmapped key (valid=0): no matrix change, no key_event.
- CoCo SHIFT (row6, col7) effective level = ovr_mode==1 ? 1 : ovr_mode==2 ? 0 : |pc_shift.
- Row readback: row r is low if some column c has kb_cols[c]==0 and key(r,c) is held, with SHIFT using its effective level.
  - Additionally PA0 is low if joy_btn_r=1, and PA1 is low if joy_btn_l=1, regardless of kb_cols.
  - Result registered into kb_rows every cycle (1-cycle read latency).
- Key map (set-2 scancodes):
  - row0 cols0–7: @ A B C D E F G
  - row1: H–O; row2: P–W
  - row3: X Y Z UP DOWN LEFT RIGHT SPACE
  - row4: 0–7
  - row5: 8 9 : ; , - . /
  - row6: ENTER CLEAR BREAK – – – – SHIFT
  - Arrow keys: ext 0x75/0x72/0x6B/0x74. Backspace 0x66 = LEFT. ESC 0x76 = BREAK. Home (ext 0x6C) = CLEAR. Enter 0x5A, ext 0x5A = ENTER.
  - PC-shifted symbols with smode: Shift+2 -> '@' force off; Shift+; -> ':' force off; ' -> '7' force on; = -> '-' force on.
  - smode is taken from the lookup on press only and depends on pc_shift at that moment.
- Reset mid-operation: the FSM aborts to IDLE with no partial update and all keys released.

Decomposition:
- Package coco_kbd_pkg:
  - row/col localparams (ROW_SHIFT=6, COL_SHIFT=7, etc.)
  - smode enum
  - FSM state enum
  - struct for the lookup result
- Sub-module coco_key_lut: purely combinational, {ext, code, pc_shift_any} -> lookup result. Holds the whole scancode table so it can be tested standalone.

Test Plan:
- Reset, kb_cols=8'h00 -> kb_rows=7'h7F; joy_btn_r=1 -> kb_rows=7'h7E the following cycle.
- Toggle event press 0x1C ('A'), kb_cols=8'hFD -> kb_rows=7'h7E after 4 cycles, key_event pulses at cycle 3; release -> 7'h7F.
- Press Shift (0x12) then 0x1E ('2'), kb_cols=8'hFE -> kb_rows=7'h7E (@). With kb_cols=8'h7F -> 7'h7F, shift forced off. Release 0x1E, kb_cols=8'h7F -> 7'h3F, shift visible again.
- Ext 0x75 press, kb_cols=8'hF7 -> 7'h77 (UP, row3); non-ext 0x75 -> no change, no key_event.
- Two toggles 1 cycle apart ('A' then 'B') -> both processed; kb_cols=8'hF9 -> row0 low; two key_event pulses.
- Hold 'A', assert reset for 1 cycle mid-DECODE of a second event -> kb_rows=7'h7F, matrix empty, no key_event.
